// File: rtl/branch_resolve_unit_if.sv
// Pipeline <-> branch resolve unit signal bundle: fetch prediction, execute outcome, resolve outputs.
// Purely wiring, no latency of its own.
// No backpressure: stall_d/stall_e are the only hold controls; BRU_PERF_CNT_EN adds the counter signals.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
`ifdef BRU_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic            f_predict_taken;
    logic [XLEN-1:0] f_pred_target;
    logic            stall_d;
    logic            stall_e;
    logic            e_is_branch;
    logic            e_cond_pass;
    logic [XLEN-1:0] e_target;
    logic            branch;
    logic            taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;
`endif

    // Pipeline side: drives fetch/execute information, consumes resolve results.
    modport master (
        output f_valid, f_pc, f_predict_taken, f_pred_target,
        output stall_d, stall_e, e_is_branch, e_cond_pass, e_target,
        input  branch, taken, redirect_valid, redirect_pc, flush
`ifdef BRU_PERF_CNT_EN
        , input br_count, mp_count
`endif
    );

    // Branch resolve unit side.
    modport slave (
        input  f_valid, f_pc, f_predict_taken, f_pred_target,
        input  stall_d, stall_e, e_is_branch, e_cond_pass, e_target,
        output branch, taken, redirect_valid, redirect_pc, flush
`ifdef BRU_PERF_CNT_EN
        , output br_count, mp_count
`endif
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: shadows fetch predictions through D/E and checks them against the outcome.
// Latency 1: branch/taken/redirect one cycle after resolve; flush held FLUSH_CYCLES cycles from that cycle.
// No backpressure: stall_e defers resolution, stalls never pause a flush; BRU_PERF_CNT_EN adds saturating counters.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
`ifdef BRU_PERF_CNT_EN
    , parameter int CNT_W      = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bru
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    // Decode / Execute shadow registers
    logic            d_vld_q, d_vld_d, d_pt_q, d_pt_d;
    logic [XLEN-1:0] d_pc_q, d_pc_d, d_tgt_q, d_tgt_d;
    logic            e_vld_q, e_vld_d, e_pt_q, e_pt_d;
    logic [XLEN-1:0] e_pc_q, e_pc_d, e_tgt_q, e_tgt_d;

    // Flush FSM
    state_t          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            flush;

    // Registered outputs
    logic            branch_q, taken_q, rdr_vld_q;
    logic [XLEN-1:0] rdr_pc_q;

    logic            resolve, mispredict;
    logic [XLEN-1:0] correct_pc;

    // Shadow register next state: stalls hold, a stalled Decode feeds a bubble, flush kills both.
    always_comb begin
        d_vld_d = d_vld_q;
        d_pc_d  = d_pc_q;
        d_pt_d  = d_pt_q;
        d_tgt_d = d_tgt_q;
        e_vld_d = e_vld_q;
        e_pc_d  = e_pc_q;
        e_pt_d  = e_pt_q;
        e_tgt_d = e_tgt_q;
        if (!bru.stall_d) begin
            d_vld_d = bru.f_valid;
            d_pc_d  = bru.f_pc;
            d_pt_d  = bru.f_predict_taken;
            d_tgt_d = bru.f_pred_target;
        end
        if (!bru.stall_e) begin
            if (bru.stall_d) begin
                e_vld_d = 1'b0;
            end else begin
                e_vld_d = d_vld_q;
                e_pc_d  = d_pc_q;
                e_pt_d  = d_pt_q;
                e_tgt_d = d_tgt_q;
            end
        end
        if (flush) begin
            d_vld_d = 1'b0;
            e_vld_d = 1'b0;
        end
    end

    // Shadow register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_vld_q <= 1'b0;
            d_pc_q  <= '0;
            d_pt_q  <= 1'b0;
            d_tgt_q <= '0;
            e_vld_q <= 1'b0;
            e_pc_q  <= '0;
            e_pt_q  <= 1'b0;
            e_tgt_q <= '0;
        end else begin
            d_vld_q <= d_vld_d;
            d_pc_q  <= d_pc_d;
            d_pt_q  <= d_pt_d;
            d_tgt_q <= d_tgt_d;
            e_vld_q <= e_vld_d;
            e_pc_q  <= e_pc_d;
            e_pt_q  <= e_pt_d;
            e_tgt_q <= e_tgt_d;
        end
    end

    // Resolve once per unstalled branch in Execute; a wrong direction or a wrong taken target mispredicts.
    always_comb begin
        resolve    = e_vld_q & bru.e_is_branch & ~bru.stall_e & (state_q == IDLE);
        mispredict = (e_pt_q != bru.e_cond_pass) |
                     (bru.e_cond_pass & e_pt_q & (e_tgt_q != bru.e_target));
        correct_pc = bru.e_cond_pass ? bru.e_target : (e_pc_q + XLEN'(4));
    end

    // Predictor update strobe and redirect, registered one cycle after the resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_q  <= 1'b0;
            taken_q   <= 1'b0;
            rdr_vld_q <= 1'b0;
            rdr_pc_q  <= '0;
        end else begin
            branch_q  <= resolve;
            taken_q   <= resolve & bru.e_cond_pass;
            rdr_vld_q <= resolve & mispredict;
            if (resolve && mispredict) begin
                rdr_pc_q <= correct_pc;
            end
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush FSM next state: enter on mispredict, leave after the down-counter reaches zero.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (resolve && mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush FSM output: flush is asserted for every cycle spent in FLUSH.
    always_comb begin
        flush = (state_q == FLUSH);
    end

    assign bru.branch         = branch_q;
    assign bru.taken          = taken_q;
    assign bru.redirect_valid = rdr_vld_q;
    assign bru.redirect_pc    = rdr_pc_q;
    assign bru.flush          = flush;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

    // Saturating resolve / mispredict counters.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (resolve && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (resolve && mispredict && (mp_cnt_q != '1)) begin
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign bru.br_count = br_cnt_q;
    assign bru.mp_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected resolve results.
// Expectations are pushed when a branch is presented in Execute, popped when the strobe appears.
// Flush length, orphan redirects, stall deferral and reset-abort are checked alongside.
module tb_branch_resolve_unit;
    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;
`ifdef BRU_PERF_CNT_EN
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(
        .XLEN(XLEN)
`ifdef BRU_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) bif ();

    branch_resolve_unit #(
        .XLEN(XLEN),
        .FLUSH_CYCLES(FLUSH_CYCLES)
`ifdef BRU_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bru(bif.slave)
    );

    typedef struct {
        logic            taken;
        logic            rv;
        logic [XLEN-1:0] rpc;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              errors = 0;
    int              checks = 0;
    int              cyc    = 0;
    int              run    = 0;
    int              n_br   = 0;
    int              n_mp   = 0;
    logic [XLEN-1:0] last_rpc = '0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model for one resolve; result is due one cycle after the current one.
    task automatic push_exp(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] ptgt,
                            input logic cond, input logic [XLEN-1:0] tgt);
        logic mp;
        mp = (pt != cond) || (cond && pt && (ptgt != tgt));
        if (mp) last_rpc = cond ? tgt : pc + 32'd4;
        sb.push_back('{cond, mp, last_rpc, cyc + 1});
        n_br++;
        if (mp) n_mp++;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            run = 0;
        end else begin
            if (bif.branch) begin
                if (sb.size() == 0) begin
                    chk_eq("spurious_br", bif.branch, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk_eq("taken", bif.taken, mon_e.taken);
                    chk_eq("redirect_valid", bif.redirect_valid, mon_e.rv);
                    chk_eq("redirect_pc", bif.redirect_pc, mon_e.rpc);
                    chk_eq("flush_at_br", bif.flush, mon_e.rv);
                    chk_eq("br_cycle", cyc, mon_e.cyc);
                end
            end else begin
                chk_eq("rv_wo_br", bif.redirect_valid, 0);
            end
            if (bif.flush) begin
                run++;
            end else if (run != 0) begin
                chk_eq("flush_len", run, FLUSH_CYCLES);
                run = 0;
            end
        end
    end

    task automatic send_br(input logic [XLEN-1:0] pc, input logic pt, input logic [XLEN-1:0] ptgt,
                           input logic cond, input logic [XLEN-1:0] tgt, input int stall);
        @(negedge clk);
        bif.f_valid         = 1'b1;
        bif.f_pc            = pc;
        bif.f_predict_taken = pt;
        bif.f_pred_target   = ptgt;
        @(negedge clk);
        bif.f_valid = 1'b0;
        @(negedge clk);
        bif.e_is_branch = 1'b1;
        bif.e_cond_pass = cond;
        bif.e_target    = tgt;
        for (int i = 0; i < stall; i++) begin
            bif.stall_e = 1'b1;
            @(negedge clk);
        end
        bif.stall_e = 1'b0;
        push_exp(pc, pt, ptgt, cond, tgt);
        @(negedge clk);
        bif.e_is_branch = 1'b0;
        repeat (FLUSH_CYCLES + 1) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bif.f_valid         = 1'b0;
        bif.f_pc            = '0;
        bif.f_predict_taken = 1'b0;
        bif.f_pred_target   = '0;
        bif.stall_d         = 1'b0;
        bif.stall_e         = 1'b0;
        bif.e_is_branch     = 1'b0;
        bif.e_cond_pass     = 1'b0;
        bif.e_target        = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_branch", bif.branch, 0);
        chk_eq("rst_taken", bif.taken, 0);
        chk_eq("rst_rv", bif.redirect_valid, 0);
        chk_eq("rst_rpc", bif.redirect_pc, 0);
        chk_eq("rst_flush", bif.flush, 0);
        chk_eq("rst_dvld", dut.d_vld_q, 0);
        chk_eq("rst_evld", dut.e_vld_q, 0);
        reset = 1'b0;

        // Correct not-taken, mispredicted direction, target mismatch, correct taken, PC wrap.
        send_br(32'h100, 1'b0, 32'h0,   1'b0, 32'h140, 0);
        send_br(32'h200, 1'b0, 32'h0,   1'b1, 32'h400, 0);
        send_br(32'h480, 1'b1, 32'h500, 1'b1, 32'h504, 0);
        send_br(32'h600, 1'b1, 32'h700, 1'b1, 32'h700, 0);
        send_br(32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 32'h10, 0);

        // Predicted taken, actually not taken, with a second branch reaching Execute during the flush.
        @(negedge clk);
        bif.f_valid = 1'b1; bif.f_pc = 32'h280; bif.f_predict_taken = 1'b1; bif.f_pred_target = 32'h300;
        @(negedge clk);
        bif.f_pc = 32'h284; bif.f_predict_taken = 1'b0; bif.f_pred_target = 32'h0;
        @(negedge clk);
        bif.f_valid = 1'b0;
        bif.e_is_branch = 1'b1; bif.e_cond_pass = 1'b0; bif.e_target = 32'h300;
        push_exp(32'h280, 1'b1, 32'h300, 1'b0, 32'h300);
        @(negedge clk);
        bif.e_cond_pass = 1'b1; bif.e_target = 32'h999;
        bif.f_valid = 1'b1; bif.f_pc = 32'h288;
        @(negedge clk);
        chk_eq("flush_dvld", dut.d_vld_q, 0);
        chk_eq("flush_evld", dut.e_vld_q, 0);
        bif.f_valid = 1'b0;
        repeat (2) @(negedge clk);
        bif.e_is_branch = 1'b0;
        repeat (2) @(negedge clk);

        // Execute stall defers the resolve until release.
        send_br(32'h800, 1'b0, 32'h0, 1'b0, 32'h0,   3);
        send_br(32'h900, 1'b1, 32'hA00, 1'b0, 32'hA00, 1);

        // Reset in the middle of a flush aborts it immediately.
        @(negedge clk);
        bif.f_valid = 1'b1; bif.f_pc = 32'hB00; bif.f_predict_taken = 1'b0;
        @(negedge clk);
        bif.f_valid = 1'b0;
        @(negedge clk);
        bif.e_is_branch = 1'b1; bif.e_cond_pass = 1'b1; bif.e_target = 32'hC00;
        push_exp(32'hB00, 1'b0, 32'h0, 1'b1, 32'hC00);
        @(negedge clk);
        bif.e_is_branch = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_eq("rstmid_flush", bif.flush, 0);
        chk_eq("rstmid_rv", bif.redirect_valid, 0);
        chk_eq("rstmid_branch", bif.branch, 0);
        last_rpc = '0;
        n_br = 0;
        n_mp = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_eq("rstmid_rpc", bif.redirect_pc, 0);
        send_br(32'hD00, 1'b1, 32'hE00, 1'b1, 32'hE00, 0);

`ifdef BRU_PERF_CNT_EN
        repeat (20) send_br(32'h1000, 1'b0, 32'h0, 1'b1, 32'h2000, 0);
        chk_eq("br_count", bif.br_count, (n_br > CMAX) ? CMAX : n_br);
        chk_eq("mp_count", bif.mp_count, (n_mp > CMAX) ? CMAX : n_mp);
`endif

        repeat (5) @(negedge clk);
        chk_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage branch resolution block, directly upstream of the 2-bit branch predictor. Carries each fetched instruction's prediction (taken flag, predicted target) through shadow Decode/Execute registers and compares it with the actual outcome in Execute. Emits the predictor update strobe (branch, taken), the mispredict redirect PC, and a multi-cycle pipeline flush.

Parameters:
XLEN, 32, PC/target width in bits
FLUSH_CYCLES, 2, cycles flush stays asserted per mispredict (min 1)
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
f_valid  in  1  fetch slot holds a valid instruction
f_pc  in  XLEN  PC of fetched instruction
f_predict_taken  in  1  predictor output sampled at fetch
f_pred_target  in  XLEN  predicted target (meaningful when f_predict_taken=1)
stall_d  in  1  Decode stage stalled
stall_e  in  1  Execute stage stalled
e_is_branch  in  1  instruction in Execute is a conditional branch
e_cond_pass  in  1  actual branch outcome (1 = taken)
e_target  in  XLEN  computed branch target
branch  out  1  predictor update strobe, 1 cycle
taken  out  1  actual outcome accompanying branch
redirect_valid  out  1  fetch must load redirect_pc, 1 cycle
redirect_pc  out  XLEN  corrected fetch PC
flush  out  1  kill Fetch/Decode contents
br_count  out  CNT_W  resolved branches (BRU_PERF_CNT_EN only)
mp_count  out  CNT_W  mispredicts (BRU_PERF_CNT_EN only)

Behaviour:
- Reset: all outputs 0, D/E shadow valids 0, FSM = IDLE, counters 0. Reset asserted mid-flush aborts it immediately.
- Shadow D register {valid, pc, pred_taken, pred_target}: hold when stall_d; else load fetch fields with valid = f_valid & ~flush.
- Shadow E register: hold when stall_e; else if stall_d, load bubble (valid=0); else load D. Both valids cleared on any cycle where flush=1.
- Resolve event (combinational): E.valid & e_is_branch & ~stall_e & state==IDLE. Evaluated once per instruction; a stalled E never resolves.
- Mispredict = (E.pred_taken != e_cond_pass) | (e_cond_pass & E.pred_taken & E.pred_target != e_target).
- Correct PC = e_cond_pass ? e_target : E.pc + 4, mod 2^XLEN; wrap at all-ones is allowed.
- Latency 1: in the cycle after a resolve, branch=1 and taken=e_cond_pass (registered). A correct prediction produces no redirect and no flush.
- FSM IDLE -> FLUSH on resolve with mispredict. The next cycle raises redirect_valid=1 and redirect_pc=correct PC for 1 cycle.
- flush=1 for exactly FLUSH_CYCLES consecutive cycles starting with that same cycle, via a down-counter loaded with FLUSH_CYCLES-1; then FLUSH -> IDLE.
- In FLUSH: resolves ignored, branch stays 0. stall_d/stall_e do not extend or pause the flush.
- redirect_pc holds its last value when redirect_valid=0 (0 after reset).
- Simultaneous stall_e with a branch in E: no resolve that cycle. Resolves on the first unstalled cycle.

Optional Feature:
BRU_PERF_CNT_EN defined:
- br_count increments on each resolve.
- mp_count increments on each mispredict resolve.
- Both saturate at 2^CNT_W-1 and reset to 0.

BRU_PERF_CNT_EN undefined:
- Counters and both ports are absent. All other behaviour is identical.

Test Plan:
1. Reset then f_valid=1, f_pc=0x100, f_predict_taken=0; two cycles later e_is_branch=1, e_cond_pass=0 -> next cycle branch=1, taken=0, redirect_valid=0, flush=0.
2. Predicted not-taken at pc 0x200; actual taken, e_target=0x400 -> next cycle branch=1, taken=1, redirect_valid=1, redirect_pc=0x400; flush high 2 cycles; D/E valids cleared.
3. Predicted taken to 0x300 at pc 0x280; actual not taken -> redirect_pc=0x284, flush 2 cycles. A branch entering E during flush -> no branch strobe.
4. Predicted taken to 0x500; actual taken to 0x504 -> target mismatch: redirect_pc=0x504, taken=1.
5. Branch in E with stall_e=1 for 3 cycles, then released -> exactly one branch pulse, 1 cycle after release. Assert reset during a flush -> flush=0 and redirect_valid=0 immediately, FSM IDLE.
6. With BRU_PERF_CNT_EN and CNT_W=4: 20 mispredicting branches -> br_count=15 and mp_count=15 (saturated). Without the macro the bench compiles without counter ports.
